// File: rtl/joystick_adc_sampler.sv
// Purpose: periodically reads joystick X/Y from XADC aux channels 3 and 11 over the DRP port.
// Latency: sample_valid pulses 2 cycles after the Y read completes; an acquisition starts every SAMPLE_PERIOD idle cycles.
// Backpressure: none; waits up to TIMEOUT cycles for drdy_in, then drops the pair and pulses adc_timeout.
// Option: define JOYSTICK_AVG_EN to average the last 4 raw samples per axis (cycle timing unchanged).
module joystick_adc_sampler #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  output logic        dwe_out,
  output logic [15:0] di_out,
  input  logic [15:0] do_in,
  input  logic        drdy_in,
  output logic [11:0] joy_x,
  output logic [11:0] joy_y,
  output logic        sample_valid,
  output logic        adc_timeout
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
  localparam logic [6:0]  ADDR_X  = 7'h13;
  localparam logic [6:0]  ADDR_Y  = 7'h1B;
  localparam logic [11:0] CENTRE  = 12'h400;

  typedef enum logic [2:0] {IDLE, REQ_X, WAIT_X, REQ_Y, WAIT_Y, PUBLISH} state_t;

  state_t        state, next_state;
  logic [PW-1:0] period_cnt;
  logic [WW-1:0] wait_cnt;
  logic [11:0]   raw_x, raw_y;
  logic          capture_x, capture_y, publish, timeout_hit;
  logic          unused_do_lsbs;

  // Read-only DRP master: write port tied off, conversion LSB padding ignored.
  assign dwe_out        = 1'b0;
  assign di_out         = 16'h0000;
  assign den_out        = (state == REQ_X) || (state == REQ_Y);
  assign unused_do_lsbs = ^do_in[3:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and one-cycle strobes; drdy_in matters only in the WAIT states and beats the timeout.
  always_comb begin
    next_state  = state;
    capture_x   = 1'b0;
    capture_y   = 1'b0;
    publish     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:    if (period_cnt == P_LAST) next_state = REQ_X;
      REQ_X:   next_state = WAIT_X;
      WAIT_X: begin
        if (drdy_in) begin
          capture_x  = 1'b1;
          next_state = REQ_Y;
        end else if (wait_cnt == W_LAST) begin
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end
      end
      REQ_Y:   next_state = WAIT_Y;
      WAIT_Y: begin
        if (drdy_in) begin
          capture_y  = 1'b1;
          next_state = PUBLISH;
        end else if (wait_cnt == W_LAST) begin
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end
      end
      PUBLISH: begin
        publish    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Idle spacing counter; restarts from 0 every time IDLE is (re)entered.
  always_ff @(posedge clk) begin
    if (rst)                                        period_cnt <= '0;
    else if (state == IDLE && period_cnt != P_LAST) period_cnt <= period_cnt + PW'(1);
    else                                            period_cnt <= '0;
  end

  // Response wait counter; cleared by each request, advanced while waiting.
  always_ff @(posedge clk) begin
    if (rst)                                         wait_cnt <= '0;
    else if (state == WAIT_X || state == WAIT_Y)     wait_cnt <= wait_cnt + WW'(1);
    else                                             wait_cnt <= '0;
  end

  // DRP address is loaded as a request state is entered and held afterwards.
  always_ff @(posedge clk) begin
    if (rst)                        daddr_out <= ADDR_X;
    else if (next_state == REQ_X)   daddr_out <= ADDR_X;
    else if (next_state == REQ_Y)   daddr_out <= ADDR_Y;
  end

  // Raw conversion capture from the 12 MSBs of the DRP read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_x <= CENTRE;
      raw_y <= CENTRE;
    end else begin
      if (capture_x) raw_x <= do_in[15:4];
      if (capture_y) raw_y <= do_in[15:4];
    end
  end

  // Event pulses: both registered so they line up with the joy_x/joy_y update.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid <= 1'b0;
      adc_timeout  <= 1'b0;
    end else begin
      sample_valid <= publish;
      adc_timeout  <= timeout_hit;
    end
  end

`ifdef JOYSTICK_AVG_EN
  // Window of four: the raw sample being published plus the three previous ones held here.
  logic [11:0] hist_x [3];
  logic [11:0] hist_y [3];
  logic [13:0] sum_x, sum_y;

  // 14-bit window sums so four 12-bit values cannot overflow.
  always_comb begin
    sum_x = 14'(raw_x) + 14'(hist_x[0]) + 14'(hist_x[1]) + 14'(hist_x[2]);
    sum_y = 14'(raw_y) + 14'(hist_y[0]) + 14'(hist_y[1]) + 14'(hist_y[2]);
  end

  // History shift and averaged output update on publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        hist_x[i] <= CENTRE;
        hist_y[i] <= CENTRE;
      end
      joy_x <= CENTRE;
      joy_y <= CENTRE;
    end else if (publish) begin
      hist_x[0] <= raw_x;
      hist_x[1] <= hist_x[0];
      hist_x[2] <= hist_x[1];
      hist_y[0] <= raw_y;
      hist_y[1] <= hist_y[0];
      hist_y[2] <= hist_y[1];
      joy_x     <= sum_x[13:2];
      joy_y     <= sum_y[13:2];
    end
  end
`else
  // Raw output update on publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      joy_x <= CENTRE;
      joy_y <= CENTRE;
    end else if (publish) begin
      joy_x <= raw_x;
      joy_y <= raw_y;
    end
  end
`endif

endmodule

// File: tb/tb_joystick_adc_sampler.sv
// Randomized scoreboard bench for joystick_adc_sampler with a DRP responder.
// Driver predicts each acquisition outcome and queues it; the monitor checks every output pulse.
// Works with and without JOYSTICK_AVG_EN.
module tb_joystick_adc_sampler;
  localparam int SP = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  daddr_out;
  logic        den_out, dwe_out;
  logic [15:0] di_out, do_in;
  logic        drdy_in;
  logic [11:0] joy_x, joy_y;
  logic        sample_valid, adc_timeout;

  always #5 clk = ~clk;

  joystick_adc_sampler #(.SAMPLE_PERIOD(SP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .daddr_out(daddr_out), .den_out(den_out), .dwe_out(dwe_out),
    .di_out(di_out), .do_in(do_in), .drdy_in(drdy_in), .joy_x(joy_x), .joy_y(joy_y),
    .sample_valid(sample_valid), .adc_timeout(adc_timeout)
  );

  typedef struct packed {
    logic        is_to;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  bit          abort = 0;
  logic [11:0] m_x, m_y;
  logic [11:0] hx [4];
  logic [11:0] hy [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: outputs sit at centre after reset; each good pair publishes the
  // raw values, or with averaging the mean of the last four raw samples.
  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      hx[i] = 12'h400;
      hy[i] = 12'h400;
    end
    m_x = 12'h400;
    m_y = 12'h400;
  endfunction

  function automatic void model_pub(input logic [11:0] rx, input logic [11:0] ry);
`ifdef JOYSTICK_AVG_EN
    int sx, sy;
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1];
      hy[i] = hy[i-1];
    end
    hx[0] = rx;
    hy[0] = ry;
    sx = 0;
    sy = 0;
    for (int i = 0; i < 4; i++) begin
      sx += int'(hx[i]);
      sy += int'(hy[i]);
    end
    m_x = 12'(sx / 4);
    m_y = 12'(sy / 4);
`else
    m_x = rx;
    m_y = ry;
`endif
  endfunction

  // Wait for a request, check it, then return drdy k cycles after it (k = TO+1 arrives after the timeout).
  task automatic serve(input logic [6:0] addr, input int k, input logic [15:0] d);
    int n = 0;
    while (!den_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!den_out) begin
      checks++;
      failures++;
      $display("FAIL den_wait no request within 100 cycles required_addr=%0h", addr);
      abort = 1;
      return;
    end
    chk("daddr", daddr_out, addr);
    chk("dwe", dwe_out, 0);
    chk("di", di_out, 0);
    repeat (k) @(negedge clk);
    chk("den_single", den_out, 0);
    chk("timeout_timing", adc_timeout, (k > TO) ? 1 : 0);
    drdy_in = 1'b1;
    do_in   = d;
    @(negedge clk);
    drdy_in = 1'b0;
    do_in   = 16'($urandom);
  endtask

  // After a timeout the next request must follow exactly SP idle cycles.
  task automatic check_restart();
    repeat (SP - 2) begin
      @(negedge clk);
      chk("den_early", den_out, 0);
    end
    @(negedge clk);
    chk("den_restart", den_out, 1);
    chk("daddr_restart", daddr_out, 7'h13);
  endtask

  task automatic do_acq(input int kx, input logic [15:0] dx, input int ky, input logic [15:0] dy, input bit spur);
    exp_t e;
    if (kx > TO || ky > TO) begin
      e.is_to = 1'b1;
    end else begin
      model_pub(dx[15:4], dy[15:4]);
      e.is_to = 1'b0;
    end
    e.x = m_x;
    e.y = m_y;
    sb.push_back(e);
    serve(7'h13, kx, dx);
    if (abort) return;
    if (kx > TO) begin
      check_restart();
      return;
    end
    serve(7'h1B, ky, dy);
    if (abort) return;
    if (ky > TO) begin
      check_restart();
      return;
    end
    chk("sv_early", sample_valid, 0);
    @(negedge clk);
    chk("sv_timing", sample_valid, 1);
    if (spur) begin
      drdy_in = 1'b1;
      do_in   = 16'hFFF0;
      @(negedge clk);
      drdy_in = 1'b0;
    end
  endtask

  // Monitor: every output pulse must match the oldest queued prediction.
  always @(negedge clk) begin
    if (!rst && (sample_valid || adc_timeout)) begin
      chk("pulse_exclusive", {31'b0, sample_valid & adc_timeout}, 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse sv=%0b to=%0b required=none", sample_valid, adc_timeout);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", adc_timeout, mon_e.is_to);
        chk("joy_x", joy_x, mon_e.x);
        chk("joy_y", joy_y, mon_e.y);
      end
    end
  end

  initial begin
    int kx, ky;
    rst     = 1'b1;
    drdy_in = 1'b0;
    do_in   = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_joy_x", joy_x, 12'h400);
    chk("rst_joy_y", joy_y, 12'h400);
    chk("rst_sv", sample_valid, 0);
    chk("rst_to", adc_timeout, 0);
    chk("rst_den", den_out, 0);
    chk("rst_daddr", daddr_out, 7'h13);
    rst = 1'b0;

    // Fixed X/Y pair repeated: raw gives 7FF/010, averaging ramps 4FF..7FF.
    repeat (4) if (!abort) do_acq(2, 16'h7FF0, 2, 16'h0100, 1'b0);
    if (!abort) do_acq(2, 16'h1230, TO + 1, 16'h4560, 1'b0);   // Y never answers in time
    if (!abort) do_acq(3, 16'hABC0, TO, 16'h5550, 1'b1);       // drdy on final wait cycle, then IDLE spurious
    if (!abort) do_acq(TO + 1, 16'h9990, 2, 16'h2220, 1'b0);   // X timeout with late drdy

    // Reset in WAIT_Y followed by a late drdy.
    if (!abort) begin
      serve(7'h13, 2, 16'h3330);
      if (!abort) begin
        while (!den_out) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        drdy_in = 1'b1;
        do_in   = 16'hEEE0;
        @(negedge clk);
        drdy_in = 1'b0;
        chk("rst_mid_joy_x", joy_x, 12'h400);
        chk("rst_mid_joy_y", joy_y, 12'h400);
        chk("rst_mid_sv", sample_valid, 0);
        chk("rst_mid_to", adc_timeout, 0);
        chk("rst_mid_den", den_out, 0);
      end
    end

    for (int i = 0; i < 40 && !abort; i++) begin
      kx = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, TO)) : TO + 1;
      ky = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, TO)) : TO + 1;
      do_acq(kx, 16'($urandom), ky, 16'($urandom), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout run exceeded 200000 time units");
    $fatal(1);
  end

endmodule
